// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: data width, the canonical NOP and the fetch FSM states.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetched instruction that IF/ID could not accept yet.
module fetch_skid_buffer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            drain_i,
  input  logic            clear_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o
);
  import riscv_pkg::*;

  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;

  // Clear beats load; a load in the same cycle as a drain refills the entry.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear_i) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      pc_d    = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory and loads IF/ID,
// honouring stalls and redirects and discarding responses made stale by a redirect.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_write_enable,
  input  logic            if_id_write_enable,
  input  logic            pc_redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  output logic            if_id_valid,
  output logic [31:0]     if_id_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic [1:0]      dbg_state
);
  import riscv_pkg::*;

  // imem handshake: imem_req is a one-cycle pulse with no back-pressure; memory answers each
  // request with exactly one imem_valid pulse one or more cycles later, never overlapping.

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [31:0]     ifid_instr_q, ifid_instr_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;

  logic            buf_valid;
  logic [31:0]     buf_instr;
  logic [XLEN-1:0] buf_pc;

  logic resp_keep;
  logic resp_to_ifid;
  logic buf_load;
  logic buf_drain;
  logic buf_empty_next;
  logic issue;

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (issue) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (pc_redirect)     state_d = imem_valid ? S_IDLE : S_DROP;
        else if (issue)      state_d = S_WAIT;
        else if (imem_valid) state_d = S_IDLE;
      end
      S_DROP: begin
        if (imem_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs / control
  // Issue is gated by reset so nothing reaches memory while it is being reset with us.
  always_comb begin
    resp_keep      = (state_q == S_WAIT) && imem_valid && !pc_redirect && !reset;
    buf_drain      = buf_valid && if_id_write_enable && !pc_redirect;
    resp_to_ifid   = resp_keep && if_id_write_enable && !buf_valid;
    buf_load       = resp_keep && !resp_to_ifid;
    buf_empty_next = !buf_load && !(buf_valid && !buf_drain);
    issue          = !reset && pc_write_enable && !pc_redirect && buf_empty_next &&
                     ((state_q == S_IDLE) || ((state_q == S_WAIT) && imem_valid));
  end

  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign dbg_state = state_q;

  fetch_skid_buffer #(
    .XLEN (XLEN)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .load_i  (buf_load),
    .drain_i (buf_drain),
    .clear_i (pc_redirect),
    .instr_i (imem_rdata),
    .pc_i    (req_pc_q),
    .valid_o (buf_valid),
    .instr_o (buf_instr),
    .pc_o    (buf_pc)
  );

  // ---------------------------------------------------------------- PC and IF/ID datapath
  always_comb begin
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;

    if (pc_redirect) begin
      pc_d = redirect_target & ~XLEN'(3);
    end else if (issue) begin
      pc_d     = pc_q + XLEN'(4);
      req_pc_d = pc_q;
    end

    // An enabled IF/ID with nothing to load becomes a bubble so nothing is seen twice.
    if (pc_redirect) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
      ifid_pc_d    = '0;
    end else if (if_id_write_enable) begin
      if (buf_valid) begin
        ifid_valid_d = 1'b1;
        ifid_instr_d = buf_instr;
        ifid_pc_d    = buf_pc;
      end else if (resp_to_ifid) begin
        ifid_valid_d = 1'b1;
        ifid_instr_d = imem_rdata;
        ifid_pc_d    = req_pc_q;
      end else begin
        ifid_valid_d = 1'b0;
        ifid_instr_d = NOP_INSTR;
        ifid_pc_d    = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
    end
  end

  assign if_id_valid = ifid_valid_q;
  assign if_id_instr = ifid_instr_q;
  assign if_id_pc    = ifid_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a transaction-level
// model of the fetch stream (expected PC sequence, kept/dropped responses, IF/ID contents).
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  // ---------------------------------------------------------------- clock / reset / DUT
  logic        clk = 1'b0;
  logic        reset;
  logic        pc_write_enable;
  logic        if_id_write_enable;
  logic        pc_redirect;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .pc_write_enable    (pc_write_enable),
    .if_id_write_enable (if_id_write_enable),
    .pc_redirect        (pc_redirect),
    .redirect_target    (redirect_target),
    .imem_req           (imem_req),
    .imem_addr          (imem_addr),
    .imem_valid         (imem_valid),
    .imem_rdata         (imem_rdata),
    .if_id_valid        (if_id_valid),
    .if_id_instr        (if_id_instr),
    .if_id_pc           (if_id_pc),
    .dbg_state          (dbg_state)
  );

  // ---------------------------------------------------------------- bench state
  int tests_run    = 0;
  int tests_failed = 0;
  int req_count    = 0;

  // memory model
  logic        mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;
  int          mem_lat  = 1;
  bit          mem_rand = 1'b0;
  logic [31:0] mem_xor  = '0;

  // reference model: next fetch PC, stale flag, undelivered instructions, IF/ID contents
  logic        rst_in   = 1'b1;
  logic [31:0] m_pc     = RST_PC;
  logic        m_stale  = 1'b0;
  logic [63:0] exp_q[$];
  logic        m_valid  = 1'b0;
  logic [31:0] m_instr  = NOP;
  logic [31:0] m_ifpc   = '0;
  bit          m_chk_pc = 1'b1;

  logic        obs_req;
  logic [31:0] obs_addr;

  // ---------------------------------------------------------------- driver + scoreboard
  task automatic cycle(input logic pwe, input logic iwe, input logic redir,
                       input logic [31:0] tgt);
    logic        resp;
    logic        keep;
    logic        exp_req;
    logic        empty_end;
    int          qs;
    logic [63:0] ent;
    reset              = rst_in;
    pc_write_enable    = pwe;
    if_id_write_enable = iwe;
    pc_redirect        = redir;
    redirect_target    = tgt;
    resp               = mem_busy && (mem_cnt == 1);
    imem_valid         = resp;
    imem_rdata         = resp ? (mem_addr ^ mem_xor) : 32'($urandom);
    #1;
    obs_req  = imem_req;
    obs_addr = imem_addr;

    keep = resp && !m_stale && !rst_in && !redir;
    if (keep) exp_q.push_back({mem_addr, mem_addr ^ mem_xor});
    qs        = exp_q.size();
    empty_end = iwe ? (qs <= 1) : (qs == 0);
    exp_req   = !rst_in && pwe && !redir && empty_end && (!mem_busy || (resp && !m_stale));

    tests_run++;
    if (obs_req !== exp_req) begin
      tests_failed++;
      $display("FAIL imem_req t=%0t got %b expected %b", $time, obs_req, exp_req);
    end
    if (exp_req) begin
      tests_run++;
      if (obs_addr !== m_pc) begin
        tests_failed++;
        $display("FAIL imem_addr t=%0t got %h expected %h", $time, obs_addr, m_pc);
      end
    end

    if (mem_busy && !resp) mem_cnt--;
    if (rst_in) begin
      exp_q.delete();
      mem_busy = 1'b0;
      m_stale  = 1'b0;
      m_pc     = RST_PC;
    end else if (redir) begin
      exp_q.delete();
      if (resp) begin
        mem_busy = 1'b0;
        m_stale  = 1'b0;
      end else if (mem_busy) begin
        m_stale = 1'b1;
      end
      m_pc = tgt & ~32'h3;
    end else begin
      if (resp) begin
        mem_busy = 1'b0;
        m_stale  = 1'b0;
      end
      if (exp_req) begin
        mem_busy = 1'b1;
        mem_addr = m_pc;
        mem_cnt  = mem_rand ? int'($urandom_range(1, 3)) : mem_lat;
        m_pc     = m_pc + 32'd4;
        req_count++;
      end
    end

    @(posedge clk);
    #1;
    if (rst_in || redir) begin
      m_valid  = 1'b0;
      m_instr  = NOP;
      m_ifpc   = '0;
      m_chk_pc = 1'b1;
    end else if (iwe) begin
      if (exp_q.size() > 0) begin
        ent      = exp_q.pop_front();
        m_valid  = 1'b1;
        m_ifpc   = ent[63:32];
        m_instr  = ent[31:0];
        m_chk_pc = 1'b1;
      end else begin
        m_valid  = 1'b0;
        m_instr  = NOP;
        m_chk_pc = 1'b0;
      end
    end
    tests_run++;
    if (if_id_valid !== m_valid || if_id_instr !== m_instr ||
        (m_chk_pc && if_id_pc !== m_ifpc)) begin
      tests_failed++;
      $display("FAIL if_id t=%0t got v=%b i=%h pc=%h expected v=%b i=%h pc=%h",
               $time, if_id_valid, if_id_instr, if_id_pc, m_valid, m_instr, m_ifpc);
    end
  endtask

  // ---------------------------------------------------------------- scenarios
  task automatic test_reset();
    rst_in   = 1'b1;
    mem_rand = 1'b0;
    mem_lat  = 1;
    mem_xor  = '0;
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    tests_run++;
    if (imem_addr !== RST_PC || imem_req !== 1'b0 || dbg_state !== S_IDLE) begin
      tests_failed++;
      $display("FAIL reset_state got addr=%h req=%b st=%0d expected addr=%h req=0 st=%0d",
               imem_addr, imem_req, dbg_state, RST_PC, S_IDLE);
    end
    rst_in = 1'b0;
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    tests_run++;
    if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL first_fetch got req=%b addr=%h expected req=1 addr=0", obs_req, obs_addr);
    end
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      tests_run++;
      if (obs_addr !== 32'(4 * i) || if_id_valid !== 1'b1 || if_id_pc !== 32'(4 * (i - 1))) begin
        tests_failed++;
        $display("FAIL stream_%0d got addr=%h v=%b pc=%h expected addr=%h v=1 pc=%h", i,
                 obs_addr, if_id_valid, if_id_pc, 32'(4 * i), 32'(4 * (i - 1)));
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      tests_run++;
      if (obs_req !== 1'b0 || if_id_valid !== 1'b1 || if_id_pc !== 32'h8) begin
        tests_failed++;
        $display("FAIL stall_hold_%0d got req=%b v=%b pc=%h expected req=0 v=1 pc=8", i,
                 obs_req, if_id_valid, if_id_pc);
      end
    end
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    tests_run++;
    if (obs_req !== 1'b1 || obs_addr !== 32'h10 || if_id_pc !== 32'hC || if_id_instr !== 32'hC) begin
      tests_failed++;
      $display("FAIL stall_release got req=%b addr=%h pc=%h i=%h expected req=1 addr=10 pc=c i=c",
               obs_req, obs_addr, if_id_pc, if_id_instr);
    end
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    tests_run++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'h10) begin
      tests_failed++;
      $display("FAIL stall_next got v=%b pc=%h expected v=1 pc=10", if_id_valid, if_id_pc);
    end
  endtask

  task automatic test_redirect_wait();
    mem_lat = 3;
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    tests_run++;
    if (obs_addr !== 32'h18) begin
      tests_failed++;
      $display("FAIL rw_issue got addr=%h expected 18", obs_addr);
    end
    cycle(1'b1, 1'b1, 1'b1, 32'h103);
    tests_run++;
    if (obs_req !== 1'b0 || if_id_valid !== 1'b0 || if_id_instr !== NOP || dbg_state !== S_DROP) begin
      tests_failed++;
      $display("FAIL rw_flush got req=%b v=%b i=%h st=%0d expected req=0 v=0 i=%h st=%0d",
               obs_req, if_id_valid, if_id_instr, dbg_state, NOP, S_DROP);
    end
    mem_lat = 1;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      tests_run++;
      if (obs_req !== 1'b0 || if_id_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL rw_drop_%0d got req=%b v=%b expected req=0 v=0", i, obs_req, if_id_valid);
      end
    end
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    tests_run++;
    if (obs_req !== 1'b1 || obs_addr !== 32'h100) begin
      tests_failed++;
      $display("FAIL rw_target got req=%b addr=%h expected req=1 addr=100", obs_req, obs_addr);
    end
  endtask

  task automatic test_redirect_coincident();
    cycle(1'b1, 1'b1, 1'b1, 32'h200);
    tests_run++;
    if (obs_req !== 1'b0 || dbg_state !== S_IDLE || if_id_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rc_flush got req=%b st=%0d v=%b expected req=0 st=%0d v=0",
               obs_req, dbg_state, if_id_valid, S_IDLE);
    end
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    tests_run++;
    if (obs_req !== 1'b1 || obs_addr !== 32'h200) begin
      tests_failed++;
      $display("FAIL rc_target got req=%b addr=%h expected req=1 addr=200", obs_req, obs_addr);
    end
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    tests_run++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'h200 || if_id_instr !== 32'h200) begin
      tests_failed++;
      $display("FAIL rc_deliver got v=%b pc=%h i=%h expected v=1 pc=200 i=200",
               if_id_valid, if_id_pc, if_id_instr);
    end
  endtask

  task automatic test_reset_in_drop();
    rst_in = 1'b1;
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    rst_in  = 1'b0;
    mem_lat = 3;
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h300);
    tests_run++;
    if (dbg_state !== S_DROP) begin
      tests_failed++;
      $display("FAIL rd_enter got st=%0d expected %0d", dbg_state, S_DROP);
    end
    rst_in = 1'b1;
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    tests_run++;
    if (if_id_valid !== 1'b0 || imem_addr !== RST_PC || dbg_state !== S_IDLE) begin
      tests_failed++;
      $display("FAIL rd_reset got v=%b addr=%h st=%0d expected v=0 addr=%h st=%0d",
               if_id_valid, imem_addr, dbg_state, RST_PC, S_IDLE);
    end
    rst_in  = 1'b0;
    mem_lat = 1;
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    tests_run++;
    if (obs_req !== 1'b1 || obs_addr !== RST_PC) begin
      tests_failed++;
      $display("FAIL rd_refetch got req=%b addr=%h expected req=1 addr=%h", obs_req, obs_addr, RST_PC);
    end
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    tests_run++;
    if (if_id_valid !== 1'b1 || if_id_pc !== RST_PC) begin
      tests_failed++;
      $display("FAIL rd_accept got v=%b pc=%h expected v=1 pc=%h", if_id_valid, if_id_pc, RST_PC);
    end
  endtask

  task automatic test_wrap();
    bit seen;
    mem_lat = 1;
    seen    = 1'b0;
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
    for (int i = 0; i < 4 && !seen; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      seen = obs_req;
    end
    tests_run++;
    if (!seen || obs_addr !== 32'hFFFF_FFFC) begin
      tests_failed++;
      $display("FAIL wrap_first got seen=%b addr=%h expected seen=1 addr=fffffffc", seen, obs_addr);
    end
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    tests_run++;
    if (obs_addr !== 32'h0 || if_id_pc !== 32'hFFFF_FFFC) begin
      tests_failed++;
      $display("FAIL wrap_second got addr=%h pc=%h expected addr=0 pc=fffffffc", obs_addr, if_id_pc);
    end
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    tests_run++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_deliver got v=%b pc=%h expected v=1 pc=0", if_id_valid, if_id_pc);
    end
  endtask

  task automatic test_random();
    int start_reqs;
    mem_rand   = 1'b1;
    mem_xor    = 32'h5A5A_A5A5;
    start_reqs = req_count;
    for (int i = 0; i < 3000; i++) begin
      rst_in = ($urandom_range(0, 199) == 0);
      cycle(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 19) == 0), 32'($urandom));
    end
    rst_in = 1'b0;
    repeat (10) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    tests_run++;
    if (exp_q.size() != 0 || (req_count - start_reqs) < 500) begin
      tests_failed++;
      $display("FAIL random_drain got pending=%0d reqs=%0d expected pending=0 reqs>=500",
               exp_q.size(), req_count - start_reqs);
    end
  endtask

  // ---------------------------------------------------------------- sequence and report
  initial begin
    reset              = 1'b1;
    pc_write_enable    = 1'b0;
    if_id_write_enable = 1'b0;
    pc_redirect        = 1'b0;
    redirect_target    = '0;
    imem_valid         = 1'b0;
    imem_rdata         = '0;
    #1;
    test_reset();
    test_stall();
    test_redirect_wait();
    test_redirect_coincident();
    test_reset_in_drop();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t simulation did not complete", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
